// File: rtl/clk_div_sched.sv
// clk_div_sched: run-controlled, reprogrammable 50%-duty clock divider.
// Produces a registered divided clock plus one-cycle rise/fall strobes for
// logic in the clk domain. Start, stop and ratio changes take effect only
// at safe points, so clk_out never glitches or produces a runt high phase.
// Ratio changes requested while running are held and applied at the next
// period boundary, which is the fall toggle.
// Optional build macro CLK_DIV_SCHED_PERIOD_CNT_EN adds a saturating 16-bit
// period counter (period_cnt) with a synchronous clear input (period_clr).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | output parked low, counter cleared, ratio loads directly
// RUN      | dividing; ratio changes are held pending until a fall toggle
// STOPPING | run dropped while high; finish the high phase, then go IDLE
module clk_div_sched #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic [CNT_W-1:0] div_active,
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
    input  logic             period_clr,
    output logic [15:0]      period_cnt,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             rise_stb_q, rise_stb_d;
    logic             fall_stb_q, fall_stb_d;
    logic             cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0] div_active_q, div_active_d;
    logic             pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;

    logic [CNT_W-1:0] half_m1;
    logic             toggle;
    logic             fall_tog;
    logic             accept;
    logic             ratio_ok;
    logic             to_idle;

    // Half-period terminal count and request qualification
    assign half_m1  = (div_active_q >> 1) - CNT_W'(1);
    assign toggle   = (state_q != IDLE) && (cnt_q == half_m1);
    assign fall_tog = toggle && clk_out_q;
    assign accept   = cfg_valid && !pend_valid_q;
    assign ratio_ok = !cfg_div[0] && (cfg_div >= CNT_W'(2));
    assign to_idle  = (state_q != IDLE) && (state_d == IDLE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: stopping in the low phase is immediate, in the high phase
    // it waits for the fall toggle so the high phase is never cut short
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (run) state_d = RUN;
            end
            RUN: begin
                if (!run) begin
                    if (!clk_out_q || fall_tog) state_d = IDLE;
                    else                        state_d = STOPPING;
                end
            end
            STOPPING: begin
                if (run)           state_d = RUN;
                else if (fall_tog) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath: counter, toggle, strobes and ratio scheduling
    always_comb begin
        cnt_d        = cnt_q;
        clk_out_d    = clk_out_q;
        rise_stb_d   = 1'b0;
        fall_stb_d   = 1'b0;
        div_active_d = div_active_q;
        pend_valid_d = pend_valid_q;
        pend_div_d   = pend_div_q;
        cfg_err_d    = accept && !ratio_ok;

        if (state_q == IDLE) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end else if (to_idle) begin
            // a rise due this cycle is suppressed; a fall still strobes
            cnt_d      = '0;
            clk_out_d  = 1'b0;
            fall_stb_d = clk_out_q;
            if (pend_valid_q) begin
                div_active_d = pend_div_q;
                pend_valid_d = 1'b0;
            end
        end else if (toggle) begin
            cnt_d      = '0;
            clk_out_d  = !clk_out_q;
            rise_stb_d = !clk_out_q;
            fall_stb_d = clk_out_q;
            if (clk_out_q && pend_valid_q) begin
                div_active_d = pend_div_q;
                pend_valid_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // a request accepted at or after the final edge into IDLE loads
        // directly; otherwise it waits for a later fall toggle
        if (accept && ratio_ok) begin
            if (state_q == IDLE || to_idle) begin
                div_active_d = cfg_div;
            end else begin
                pend_valid_d = 1'b1;
                pend_div_d   = cfg_div;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            clk_out_q    <= 1'b0;
            rise_stb_q   <= 1'b0;
            fall_stb_q   <= 1'b0;
            cfg_err_q    <= 1'b0;
            div_active_q <= DEF_DIV;
            pend_valid_q <= 1'b0;
            pend_div_q   <= '0;
        end else begin
            cnt_q        <= cnt_d;
            clk_out_q    <= clk_out_d;
            rise_stb_q   <= rise_stb_d;
            fall_stb_q   <= fall_stb_d;
            cfg_err_q    <= cfg_err_d;
            div_active_q <= div_active_d;
            pend_valid_q <= pend_valid_d;
            pend_div_q   <= pend_div_d;
        end
    end

`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
    logic [15:0] period_cnt_q, period_cnt_d;

    // Completed-period counter: clear wins, otherwise count falls, saturating
    always_comb begin
        period_cnt_d = period_cnt_q;
        if (period_clr) begin
            period_cnt_d = '0;
        end else if (fall_stb_d && (period_cnt_q != 16'hFFFF)) begin
            period_cnt_d = period_cnt_q + 16'd1;
        end
    end

    // Period counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cnt_q <= '0;
        end else begin
            period_cnt_q <= period_cnt_d;
        end
    end

    assign period_cnt = period_cnt_q;
`endif

    assign cfg_ready  = !pend_valid_q;
    assign cfg_err    = cfg_err_q;
    assign clk_out    = clk_out_q;
    assign rise_stb   = rise_stb_q;
    assign fall_stb   = fall_stb_q;
    assign div_active = div_active_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched: expected {clk_out, rise_stb, fall_stb} per cycle
// is queued from a closed-form waveform description when stimulus starts,
// then popped and compared cycle by cycle; control outputs checked inline.
module tb_clk_div_sched;

    logic       clk;
    logic       reset;
    logic       run;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       clk_out;
    logic       rise_stb;
    logic       fall_stb;
    logic [7:0] div_active;
    logic       busy;
    logic       period_clr;
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif

    int tests  = 0;
    int failed = 0;

    logic [2:0] sb[$];

    clk_div_sched #(.CNT_W(8), .DEFAULT_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .clk_out    (clk_out),
        .rise_stb   (rise_stb),
        .fall_stb   (fall_stb),
        .div_active (div_active),
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
        .period_clr (period_clr),
        .period_cnt (period_cnt),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waveform of a divide-by-d run, cycle index k counted from the RUN entry
    // edge: low for d/2 cycles then high for d/2; the very first cycle of a
    // run has no fall strobe.
    function automatic void push_wave(int d, int first, int n, bit first_run);
        for (int k = first; k < first + n; k++) begin
            int pos;
            pos = k % d;
            sb.push_back({pos >= d / 2, pos == d / 2, (pos == 0) && !(first_run && k == 0)});
        end
    endfunction

    function automatic void push_idle(int n);
        for (int k = 0; k < n; k++) sb.push_back(3'b000);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        run        = 1'b0;
        cfg_valid  = 1'b0;
        cfg_div    = 8'd0;
        period_clr = 1'b0;
        sb.delete();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        run = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0; period_clr = 1'b0;
        reset = 1'b0;
        #2 reset = 1'b1;
        #2;
        tests++;
        if ({clk_out, rise_stb, fall_stb, cfg_err, cfg_ready, busy, div_active} !== {6'b000010, 8'd4}) begin
            failed++;
            $display("FAIL reset_values got clk_out=%b rise=%b fall=%b err=%b ready=%b busy=%b div=%0d exp 0 0 0 0 1 0 4",
                     clk_out, rise_stb, fall_stb, cfg_err, cfg_ready, busy, div_active);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        push_idle(10);
        for (int i = 0; i < 10; i++) begin
            logic [2:0] e;
            step();
            e = sb.pop_front();
            tests++;
            if ({clk_out, rise_stb, fall_stb, busy} !== {e, 1'b0}) begin
                failed++;
                $display("FAIL idle_quiet cyc %0d got wave=%b busy=%b exp wave=%b busy=0",
                         i, {clk_out, rise_stb, fall_stb}, busy, e);
            end
        end
    endtask

    task automatic test_run_div4();
        do_reset();
        run = 1'b1;
        push_wave(4, 0, 12, 1'b1);
        for (int i = 0; i < 12; i++) begin
            logic [2:0] e;
            step();
            e = sb.pop_front();
            tests++;
            if ({clk_out, rise_stb, fall_stb, busy} !== {e, 1'b1}) begin
                failed++;
                $display("FAIL run_div4 cyc %0d got wave=%b busy=%b exp wave=%b busy=1",
                         i, {clk_out, rise_stb, fall_stb}, busy, e);
            end
        end
    endtask

    task automatic test_cfg_change();
        do_reset();
        run = 1'b1;
        push_wave(4, 0, 12, 1'b1);
        push_wave(6, 0, 13, 1'b0);
        for (int i = 0; i < 25; i++) begin
            logic [2:0] e;
            step();
            e = sb.pop_front();
            tests++;
            if ({clk_out, rise_stb, fall_stb} !== e) begin
                failed++;
                $display("FAIL cfg_change_wave cyc %0d got %b exp %b", i, {clk_out, rise_stb, fall_stb}, e);
            end
            if (i == 11) begin
                tests++;
                if ({cfg_ready, div_active} !== {1'b0, 8'd4}) begin
                    failed++;
                    $display("FAIL cfg_pending got ready=%b div=%0d exp ready=0 div=4", cfg_ready, div_active);
                end
                cfg_valid = 1'b0;
            end
            if (i == 12) begin
                tests++;
                if ({cfg_ready, div_active} !== {1'b1, 8'd6}) begin
                    failed++;
                    $display("FAIL cfg_applied got ready=%b div=%0d exp ready=1 div=6", cfg_ready, div_active);
                end
            end
            if (i == 10) begin
                cfg_valid = 1'b1;
                cfg_div   = 8'd6;
            end
        end
    endtask

    task automatic test_cfg_at_boundary();
        do_reset();
        run = 1'b1;
        push_wave(4, 0, 9, 1'b1);
        push_wave(6, 1, 8, 1'b0);
        for (int i = 0; i < 17; i++) begin
            logic [2:0] e;
            step();
            e = sb.pop_front();
            tests++;
            if ({clk_out, rise_stb, fall_stb} !== e) begin
                failed++;
                $display("FAIL cfg_boundary_wave cyc %0d got %b exp %b", i, {clk_out, rise_stb, fall_stb}, e);
            end
            if (i == 4) begin
                tests++;
                if ({cfg_ready, div_active} !== {1'b0, 8'd4}) begin
                    failed++;
                    $display("FAIL cfg_boundary_held got ready=%b div=%0d exp ready=0 div=4", cfg_ready, div_active);
                end
                cfg_valid = 1'b0;
            end
            if (i == 8) begin
                tests++;
                if ({cfg_ready, div_active} !== {1'b1, 8'd6}) begin
                    failed++;
                    $display("FAIL cfg_boundary_apply got ready=%b div=%0d exp ready=1 div=6", cfg_ready, div_active);
                end
            end
            if (i == 3) begin
                cfg_valid = 1'b1;
                cfg_div   = 8'd6;
            end
        end
    endtask

    task automatic test_cfg_err();
        do_reset();
        run = 1'b1;
        push_wave(4, 0, 16, 1'b1);
        for (int i = 0; i < 16; i++) begin
            logic [2:0] e;
            logic       exp_err;
            step();
            e = sb.pop_front();
            exp_err = (i == 6) || (i == 10);
            tests++;
            if ({clk_out, rise_stb, fall_stb, cfg_err} !== {e, exp_err}) begin
                failed++;
                $display("FAIL cfg_err cyc %0d got wave=%b err=%b exp wave=%b err=%b",
                         i, {clk_out, rise_stb, fall_stb}, cfg_err, e, exp_err);
            end
            if (i == 6 || i == 10) cfg_valid = 1'b0;
            if (i == 5) begin cfg_valid = 1'b1; cfg_div = 8'd3; end
            if (i == 9) begin cfg_valid = 1'b1; cfg_div = 8'd0; end
        end
        tests++;
        if ({cfg_ready, div_active} !== {1'b1, 8'd4}) begin
            failed++;
            $display("FAIL cfg_err_nochange got ready=%b div=%0d exp ready=1 div=4", cfg_ready, div_active);
        end
    endtask

    task automatic test_stop();
        // run dropped right after the rise: full high phase, then IDLE
        do_reset();
        run = 1'b1;
        push_wave(4, 0, 5, 1'b1);
        push_idle(4);
        for (int i = 0; i < 9; i++) begin
            logic [2:0] e;
            step();
            e = sb.pop_front();
            tests++;
            if ({clk_out, rise_stb, fall_stb, busy} !== {e, i <= 3}) begin
                failed++;
                $display("FAIL stop_high cyc %0d got wave=%b busy=%b exp wave=%b busy=%b",
                         i, {clk_out, rise_stb, fall_stb}, busy, e, i <= 3);
            end
            if (i == 2) run = 1'b0;
        end

        // run re-raised while STOPPING: waveform continues unbroken
        do_reset();
        run = 1'b1;
        push_wave(4, 0, 12, 1'b1);
        for (int i = 0; i < 12; i++) begin
            logic [2:0] e;
            step();
            e = sb.pop_front();
            tests++;
            if ({clk_out, rise_stb, fall_stb, busy} !== {e, 1'b1}) begin
                failed++;
                $display("FAIL stop_reraise cyc %0d got wave=%b busy=%b exp wave=%b busy=1",
                         i, {clk_out, rise_stb, fall_stb}, busy, e);
            end
            if (i == 2) run = 1'b0;
            if (i == 3) run = 1'b1;
        end

        // run dropped in the low phase just before a rise: no rise at all
        do_reset();
        run = 1'b1;
        push_wave(4, 0, 6, 1'b1);
        push_idle(4);
        for (int i = 0; i < 10; i++) begin
            logic [2:0] e;
            step();
            e = sb.pop_front();
            tests++;
            if ({clk_out, rise_stb, fall_stb, busy} !== {e, i <= 5}) begin
                failed++;
                $display("FAIL stop_low cyc %0d got wave=%b busy=%b exp wave=%b busy=%b",
                         i, {clk_out, rise_stb, fall_stb}, busy, e, i <= 5);
            end
            if (i == 5) run = 1'b0;
        end
    endtask

    task automatic test_idle_cfg();
        do_reset();
        cfg_valid = 1'b1;
        cfg_div   = 8'd10;
        step();
        tests++;
        if ({div_active, cfg_ready, busy} !== {8'd10, 1'b1, 1'b0}) begin
            failed++;
            $display("FAIL idle_cfg_load got div=%0d ready=%b busy=%b exp div=10 ready=1 busy=0",
                     div_active, cfg_ready, busy);
        end
        cfg_div = 8'd2;
        run     = 1'b1;
        push_wave(2, 0, 6, 1'b1);
        for (int i = 0; i < 6; i++) begin
            logic [2:0] e;
            step();
            e = sb.pop_front();
            tests++;
            if ({clk_out, rise_stb, fall_stb, div_active} !== {e, 8'd2}) begin
                failed++;
                $display("FAIL idle_cfg_run_div2 cyc %0d got wave=%b div=%0d exp wave=%b div=2",
                         i, {clk_out, rise_stb, fall_stb}, div_active, e);
            end
            cfg_valid = 1'b0;
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        run = 1'b1;
        push_wave(4, 0, 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            logic [2:0] e;
            step();
            e = sb.pop_front();
            tests++;
            if ({clk_out, rise_stb, fall_stb} !== e) begin
                failed++;
                $display("FAIL rstpend_pre cyc %0d got %b exp %b", i, {clk_out, rise_stb, fall_stb}, e);
            end
            if (i == 3) begin
                tests++;
                if (cfg_ready !== 1'b0) begin
                    failed++;
                    $display("FAIL rstpend_pending got ready=%b exp 0", cfg_ready);
                end
                cfg_valid = 1'b0;
            end
            if (i == 2) begin
                cfg_valid = 1'b1;
                cfg_div   = 8'd8;
            end
        end
        reset = 1'b1;
        run   = 1'b0;
        #1;
        tests++;
        if ({clk_out, rise_stb, fall_stb, cfg_err, cfg_ready, busy, div_active} !== {6'b000010, 8'd4}) begin
            failed++;
            $display("FAIL rstpend_async got clk_out=%b rise=%b fall=%b err=%b ready=%b busy=%b div=%0d exp 0 0 0 0 1 0 4",
                     clk_out, rise_stb, fall_stb, cfg_err, cfg_ready, busy, div_active);
        end
        repeat (3) @(posedge clk);
        #1;
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
        tests++;
        if (period_cnt !== 16'd0) begin
            failed++;
            $display("FAIL rstpend_period_rst got %0d exp 0", period_cnt);
        end
`endif
        reset = 1'b0;
        step();
        run = 1'b1;
        push_wave(4, 0, 12, 1'b1);
        for (int i = 0; i < 12; i++) begin
            logic [2:0] e;
            step();
            e = sb.pop_front();
            tests++;
            if ({clk_out, rise_stb, fall_stb, div_active, cfg_ready} !== {e, 8'd4, 1'b1}) begin
                failed++;
                $display("FAIL rstpend_post cyc %0d got wave=%b div=%0d ready=%b exp wave=%b div=4 ready=1",
                         i, {clk_out, rise_stb, fall_stb}, div_active, cfg_ready, e);
            end
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
            begin
                logic [15:0] exp_pc;
                exp_pc = (i < 4) ? 16'd0 : (i < 7) ? 16'd1 : (i < 8) ? 16'd0 : 16'd1;
                tests++;
                if (period_cnt !== exp_pc) begin
                    failed++;
                    $display("FAIL period_cnt cyc %0d got %0d exp %0d", i, period_cnt, exp_pc);
                end
            end
            period_clr = (i == 6);
`endif
        end
    endtask

    initial begin
        test_reset();
        test_run_div4();
        test_cfg_change();
        test_cfg_at_boundary();
        test_cfg_err();
        test_stop();
        test_idle_cfg();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
- Run-controlled, reprogrammable clock divider/scheduler for the processor's derived clock domains (imem/dmem/regfile/proc clocks).
- Generates a 50%-duty divided clock plus single-cycle rise/fall strobes for clk-domain logic.
- Sequences start/stop and divide-ratio changes so the output never glitches or produces a runt half-period.
- Sits between the top-level clock source and the per-domain clock/enable consumers.

Parameters:
- CNT_W, 8, width of divide-ratio and half-period counter.
- DEFAULT_DIV, 4, divide ratio loaded on reset; must be even, >=2, < 2^CNT_W.

Ports:
- clk  in  1  source clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = generate output, 0 = stop at a safe boundary
- cfg_valid  in  1  new divide ratio offered
- cfg_div  in  CNT_W  requested divide ratio (full period in clk cycles)
- cfg_ready  out  1  1 = cfg_valid accepted this cycle
- cfg_err  out  1  one-cycle pulse: the accepted cfg_div was invalid and was dropped
- clk_out  out  1  divided clock, registered
- rise_stb  out  1  high in the cycle clk_out becomes 1
- fall_stb  out  1  high in the cycle clk_out becomes 0
- div_active  out  CNT_W  ratio currently in effect
- busy  out  1  1 in RUN or STOPPING

Behaviour:
- Reset (async): state=IDLE; clk_out=0; cnt=0; div_active=DEFAULT_DIV; no pending config; cfg_ready=1; cfg_err, rise_stb, fall_stb=0.
- half = div_active>>1. All outputs are registered.
- IDLE: clk_out=0, cnt=0. If run=1, go to RUN next cycle.
- RUN: cnt increments each cycle. When cnt==half-1, set cnt to 0 and toggle clk_out in the same edge.
  - Rise toggle asserts rise_stb; fall toggle asserts fall_stb, each for that one cycle.
  - The first rise occurs half cycles after entering RUN.
  - div=4 reproduces the legacy divide-by-4 waveform: 2 low, 2 high.
- Period boundary = the fall toggle.
- Stop handling:
  - run=0 in RUN with clk_out=1: go to STOPPING. Counting continues; at the fall toggle go to IDLE with cnt=0.
  - run=0 in RUN with clk_out=0: go to IDLE next cycle with cnt=0. This truncates the low phase only, which is not a glitch.
  - run=1 while in STOPPING: return to RUN with counting uninterrupted.
- Config acceptance:
  - A request is accepted when cfg_valid & cfg_ready.
  - Valid ratio: even and >=2. Otherwise cfg_err pulses the next cycle and nothing changes.
  - In IDLE, a valid ratio loads div_active next cycle.
  - In RUN/STOPPING, a valid ratio is latched as pending, and cfg_ready drops to 0 until it is applied.
  - A pending ratio is applied at the first fall toggle strictly after acceptance: div_active updates and cnt=0 in that edge.
  - If the block enters IDLE with a config still pending, the pending value is applied on entry.
- Simultaneous events:
  - cfg accepted in the same cycle as a fall toggle: held for the next boundary.
  - run=0 and a pending cfg in the same cycle: stop rules apply, then the config is applied on entering IDLE.
  - run and cfg_valid together in IDLE: the config applies first; RUN starts with the new ratio.
- Reset mid-operation: immediate async return to reset values; pending config is discarded.

Optional Feature:
- Macro: CLK_DIV_SCHED_PERIOD_CNT_EN.
- Defined:
  - Adds output period_cnt [15:0], which increments on every fall toggle and saturates at 16'hFFFF.
  - Adds input period_clr, a synchronous clear that wins over increment in the same cycle.
  - Reset value of period_cnt is 0.
- Undefined: these ports and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle -> clk_out=0, div_active=4, cfg_ready=1, busy=0; release reset with run=0 for 10 cycles -> no strobes.
- run=1, default div 4 -> clk_out pattern 0,0,1,1 repeating; rise_stb/fall_stb each once per 4 cycles, coincident with the matching transitions.
- In RUN at div 4, cfg_div=6 mid high phase -> cfg_ready=0 until the next fall toggle; from then on 3 low / 3 high; div_active=6 and cfg_ready=1 after that boundary.
- cfg_div=3, then cfg_div=0 -> cfg_err pulses once each; div_active unchanged; waveform undisturbed.
- Stop timing: drop run one cycle after rise_stb -> high phase completes in full, fall_stb, then IDLE. Drop run during the low phase -> IDLE next cycle, clk_out stays 0. Re-raise run in STOPPING -> no interruption.
- Reset with a pending cfg, held 3 cycles -> all outputs at reset values; pending value never applied. With CLK_DIV_SCHED_PERIOD_CNT_EN: period_cnt returns to 0 and counts 1 after the first fall toggle.
